// File: rtl/vga_frame_buffer_if.sv
// vga_frame_buffer_if: bus bundle for the scaled VGA frame buffer.
//   Write port : WR_EN/WR_X/WR_Y/WR_DATA with WR_READY handshake
//   Fill port  : CLR_REQ pulse + CLR_COLOUR, BUSY while filling
//   Read port  : ADDRH/ADDRV display address from the sync stage, COLOUR_OUT back
// master = bus/sync-stage side, slave = frame buffer.
interface vga_frame_buffer_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  WR_EN;
  logic [7:0]            WR_X;
  logic [6:0]            WR_Y;
  logic [DATA_WIDTH-1:0] WR_DATA;
  logic                  WR_READY;
  logic                  CLR_REQ;
  logic [DATA_WIDTH-1:0] CLR_COLOUR;
  logic                  BUSY;
  logic [9:0]            ADDRH;
  logic [9:0]            ADDRV;
  logic [DATA_WIDTH-1:0] COLOUR_OUT;

  modport master (
    output WR_EN, WR_X, WR_Y, WR_DATA, CLR_REQ, CLR_COLOUR, ADDRH, ADDRV,
    input  WR_READY, BUSY, COLOUR_OUT
  );

  modport slave (
    input  WR_EN, WR_X, WR_Y, WR_DATA, CLR_REQ, CLR_COLOUR, ADDRH, ADDRV,
    output WR_READY, BUSY, COLOUR_OUT
  );
endinterface

// File: rtl/vga_frame_buffer.sv
// vga_frame_buffer: HRES x VRES pixel store displayed as (1<<SCALE_SHIFT)-square
// blocks. Sits upstream of the VGA sync stage.
//   CLK, RESET : clock, synchronous active-high reset
//   bus.slave  : single-pixel write port (WR_*), fill engine (CLR_REQ/CLR_COLOUR/BUSY),
//                display read port (ADDRH/ADDRV -> COLOUR_OUT, one-cycle latency)
// Memory contents are not cleared by reset.
module vga_frame_buffer #(
  parameter int unsigned HRES        = 160,
  parameter int unsigned VRES        = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  vga_frame_buffer_if.slave bus
);

  localparam int unsigned NPIX = HRES * VRES;
  localparam int unsigned IDXW = (NPIX > 1) ? $clog2(NPIX) : 1;

  typedef enum logic {
    ST_IDLE,
    ST_FILL
  } state_t;

  state_t                state_q, state_d;
  logic [IDXW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] fill_colour_q, fill_colour_d;
  logic [DATA_WIDTH-1:0] colour_q, colour_d;

  logic [DATA_WIDTH-1:0] mem_q [NPIX];

  // Read address decode
  logic [9:0]      rd_x, rd_y;
  logic            rd_hit;
  logic [IDXW-1:0] rd_idx;

  // Write address decode
  logic            wr_hit;
  logic [IDXW-1:0] wr_idx;

  // Memory write port, shared by bus writes and the fill engine
  logic                  mem_we;
  logic [IDXW-1:0]       mem_widx;
  logic [DATA_WIDTH-1:0] mem_wdata;

  always_comb begin
    rd_x   = bus.ADDRH >> SCALE_SHIFT;
    rd_y   = bus.ADDRV >> SCALE_SHIFT;
    rd_hit = (32'(rd_x) < HRES) && (32'(rd_y) < VRES);
    // Truncation is only observed when rd_hit, where the index always fits.
    rd_idx = IDXW'(rd_y) * IDXW'(HRES) + IDXW'(rd_x);
  end

  always_comb begin
    wr_hit = (32'(bus.WR_X) < HRES) && (32'(bus.WR_Y) < VRES);
    wr_idx = IDXW'(bus.WR_Y) * IDXW'(HRES) + IDXW'(bus.WR_X);
  end

  // Reads see memory before this edge's write (read-before-write).
  always_comb begin
    colour_d = '0;
    if (rd_hit) begin
      colour_d = mem_q[rd_idx];
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    fill_colour_d = fill_colour_q;
    mem_we        = 1'b0;
    mem_widx      = wr_idx;
    mem_wdata     = bus.WR_DATA;

    unique case (state_q)
      ST_IDLE: begin
        // Out-of-range writes complete the handshake but touch nothing.
        if (bus.WR_EN && wr_hit) begin
          mem_we = 1'b1;
        end
        if (bus.CLR_REQ) begin
          fill_colour_d = bus.CLR_COLOUR;
          cnt_d         = '0;
          state_d       = ST_FILL;
        end
      end
      ST_FILL: begin
        mem_we    = 1'b1;
        mem_widx  = cnt_q;
        mem_wdata = fill_colour_q;
        if (cnt_q == IDXW'(NPIX - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset aborts a fill without committing the write of that edge.
    if (RESET) begin
      mem_we = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem_q[mem_widx] <= mem_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      fill_colour_q <= '0;
      colour_q      <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      fill_colour_q <= fill_colour_d;
      colour_q      <= colour_d;
    end
  end

  assign bus.WR_READY   = (state_q == ST_IDLE);
  assign bus.BUSY       = (state_q == ST_FILL);
  assign bus.COLOUR_OUT = colour_q;

endmodule
